// File: rtl/bk_sequencer.sv
// Backup-RAM save/load sequencer: walks every sector of the selected save slot
// through the user_io sd_rd/sd_wr/sd_ack handshake, one 512-byte sector at a time.
module bk_sequencer #(
  parameter int SECTOR_BITS = 6,
  parameter int SLOT_BITS   = 2
) (
  input  logic                 clk_sys,
  input  logic                 RESET_n,
  input  logic                 download,
  input  logic                 img_mounted,
  input  logic [31:0]          img_size,
  input  logic                 bk_load,
  input  logic                 bk_save,
  input  logic [SLOT_BITS-1:0] slot,
  input  logic                 sd_ack,
  input  logic                 sd_buff_wr,
  output logic [31:0]          sd_lba,
  output logic                 sd_rd,
  output logic                 sd_wr,
  output logic                 ena,
  output logic                 busy,
  output logic                 loading,
  output logic                 done,
  output logic                 err
);

  localparam int PAD_W = 32 - SLOT_BITS - SECTOR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN} state_t;

  state_t               state;
  logic                 dl_q, ld_q, sv_q, ack_q, ack_qq;
  logic [SLOT_BITS-1:0] slot_q;
  logic [SECTOR_BITS-1:0] sector;
  logic [9:0]           byte_cnt;

  logic dl_rise, ld_rise, sv_rise, ack_rise, ack_fall, strobe;

  // Byte counter sticks at its maximum so an over-long sector can never alias to 512.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  assign dl_rise  = download & ~dl_q;
  assign ld_rise  = bk_load & ena & ~ld_q;
  assign sv_rise  = bk_save & ena & ~sv_q;
  assign ack_rise = ack_q & ~ack_qq;
  assign ack_fall = ~ack_q & ack_qq;
  assign strobe   = sd_buff_wr & sd_ack;

  assign sd_lba = {{PAD_W{1'b0}}, slot_q, sector};

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= S_IDLE;
      dl_q     <= 1'b0;
      ld_q     <= 1'b0;
      sv_q     <= 1'b0;
      ack_q    <= 1'b0;
      ack_qq   <= 1'b0;
      slot_q   <= '0;
      sector   <= '0;
      byte_cnt <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      ena      <= 1'b0;
      busy     <= 1'b0;
      loading  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      dl_q   <= download;
      ld_q   <= bk_load & ena;
      sv_q   <= bk_save & ena;
      ack_q  <= sd_ack;
      ack_qq <= ack_q;
      done   <= 1'b0;

      // A new ROM download invalidates the save image until it is re-mounted.
      if (dl_rise)
        ena <= 1'b0;
      else if (download && img_mounted && img_size != 32'd0)
        ena <= 1'b1;

      if (dl_rise && (state == S_REQ || state == S_XFER)) begin
        sd_rd <= 1'b0;
        sd_wr <= 1'b0;
        err   <= 1'b1;
        state <= S_DRAIN;
      end else begin
        case (state)
          S_IDLE: begin
            if (ld_rise || sv_rise) begin
              slot_q  <= slot;
              sector  <= '0;
              loading <= ld_rise;
              err     <= 1'b0;
              busy    <= 1'b1;
              sd_rd   <= ld_rise;
              sd_wr   <= ~ld_rise;
              state   <= S_REQ;
            end
          end
          S_REQ: begin
            if (ack_rise) begin
              sd_rd    <= 1'b0;
              sd_wr    <= 1'b0;
              byte_cnt <= '0;
              state    <= S_XFER;
            end
          end
          S_XFER: begin
            if (strobe)
              byte_cnt <= sat_inc(byte_cnt);
            if (ack_fall) begin
              if (loading && byte_cnt != 10'd512)
                err <= 1'b1;
              if (&sector) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end else begin
                sector <= sector + SECTOR_BITS'(1);
                sd_rd  <= loading;
                sd_wr  <= ~loading;
                state  <= S_REQ;
              end
            end
          end
          S_DRAIN: begin
            // Wait for user_io to release the aborted transfer before freeing the system.
            if (!ack_q) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bk_sequencer.sv
// Bench for bk_sequencer: table of mount/enable vectors, a host model that
// serves sector requests, and scenario runs checked against expected sector walks.
module tb_bk_sequencer;

  logic        clk_sys = 1'b0;
  logic        RESET_n, download, img_mounted, bk_load, bk_save, sd_ack, sd_buff_wr;
  logic [31:0] img_size;
  logic [1:0]  slot;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, ena, busy, loading, done, err;

  int n_checks = 0;
  int n_err    = 0;
  int n_rd = 0, n_wr = 0, n_done = 0;
  int b_rd = 0, b_wr = 0, b_done = 0;
  logic rd_prev = 1'b0, wr_prev = 1'b0;
  int strobes[64];

  typedef struct {
    logic        dl;
    logic        mnt;
    logic [31:0] size;
    logic        ld;
    logic        exp_ena;
    logic        exp_busy;
    logic        exp_rd;
  } vec_t;
  vec_t vecs[11];

  always #5 clk_sys = ~clk_sys;

  bk_sequencer #(.SECTOR_BITS(6), .SLOT_BITS(2)) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .download(download),
    .img_mounted(img_mounted), .img_size(img_size), .bk_load(bk_load),
    .bk_save(bk_save), .slot(slot), .sd_ack(sd_ack), .sd_buff_wr(sd_buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .ena(ena), .busy(busy),
    .loading(loading), .done(done), .err(err)
  );

  // Request and done event counters, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (sd_rd && !rd_prev) n_rd <= n_rd + 1;
    if (sd_wr && !wr_prev) n_wr <= n_wr + 1;
    if (done) n_done <= n_done + 1;
    rd_prev <= sd_rd;
    wr_prev <= sd_wr;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0b want=%0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic snap();
    b_rd = n_rd;
    b_wr = n_wr;
    b_done = n_done;
  endtask

  task automatic check_counts(input string tag, input int erd, input int ewr, input int edone);
    chk32({tag, "_rd_reqs"}, n_rd - b_rd, erd);
    chk32({tag, "_wr_reqs"}, n_wr - b_wr, ewr);
    chk32({tag, "_dones"}, n_done - b_done, edone);
  endtask

  task automatic start(input logic ld, input logic sv, input logic [1:0] s);
    slot = s;
    bk_load = ld;
    bk_save = sv;
    chk1("pre_start_req", sd_rd | sd_wr, 1'b0);
    tick();
    bk_load = 1'b0;
    bk_save = 1'b0;
    chk1("start_rd", sd_rd, ld);
    chk1("start_wr", sd_wr, !ld);
    chk1("start_busy", busy, 1'b1);
    chk1("start_err_clr", err, 1'b0);
    chk1("start_loading", loading, ld);
  endtask

  // Host side: acks each request, delivers strobes[k] bytes, and checks the walk.
  task automatic serve(input logic is_load, input logic [1:0] slot_v, input int ack_dly,
                       input int n_sec, input int pulse_sec);
    int   base = int'(slot_v) * 64;
    logic exp_err = 1'b0;
    for (int k = 0; k < n_sec; k++) begin
      int w = 0;
      while (!(sd_rd || sd_wr) && w < 40) begin
        tick();
        w++;
      end
      chk1("req_timeout", sd_rd | sd_wr, 1'b1);
      if (!(sd_rd || sd_wr)) return;
      chk32("lba", sd_lba, 32'(base + k));
      chk1("rd_dir", sd_rd, is_load);
      chk1("wr_dir", sd_wr, !is_load);
      chk1("busy_xfer", busy, 1'b1);
      slot = 2'($urandom);
      if (k == pulse_sec) begin
        bk_save = 1'b1;
        tick();
        bk_save = 1'b0;
      end
      repeat (ack_dly) tick();
      chk1("req_hold", sd_rd | sd_wr, 1'b1);
      sd_ack = 1'b1;
      tick();
      chk1("req_ack1", sd_rd | sd_wr, 1'b1);
      tick();
      chk1("req_drop", sd_rd | sd_wr, 1'b0);
      tick();
      for (int i = 0; i < strobes[k]; i++) begin
        sd_buff_wr = 1'b1;
        tick();
      end
      sd_buff_wr = 1'b0;
      tick();
      tick();
      sd_ack = 1'b0;
      tick();
      chk32("lba_hold", sd_lba, 32'(base + k));
      chk1("no_req_yet", sd_rd | sd_wr, 1'b0);
      if (is_load && strobes[k] != 512) exp_err = 1'b1;
      tick();
      chk1("err_prog", err, exp_err);
      if (k == 63) begin
        chk1("done_pulse", done, 1'b1);
        chk1("busy_end", busy, 1'b0);
        tick();
        chk1("done_once", done, 1'b0);
        chk32("lba_idle", sd_lba, 32'(base + 63));
      end else begin
        chk1("next_req", sd_rd | sd_wr, 1'b1);
        chk1("done_mid", done, 1'b0);
      end
    end
  endtask

  initial begin
    logic       dir;
    logic [1:0] s;
    int         dly;

    RESET_n = 1'b0; download = 1'b0; img_mounted = 1'b0; img_size = 32'd0;
    bk_load = 1'b0; bk_save = 1'b0; slot = 2'd0; sd_ack = 1'b0; sd_buff_wr = 1'b0;

    //              dl    mnt   size    ld    ena   busy  rd
    vecs[0]  = '{1'b0, 1'b1, 32768, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 0,     1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32768, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 0,     1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 0,     1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 32768, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 0,     1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) tick();
    chk32("rst_lba", sd_lba, 32'd0);
    chk1("rst_rd", sd_rd, 1'b0);
    chk1("rst_wr", sd_wr, 1'b0);
    chk1("rst_ena", ena, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_loading", loading, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    RESET_n = 1'b1;
    tick();

    snap();
    for (int i = 0; i < 11; i++) begin
      download = vecs[i].dl;
      img_mounted = vecs[i].mnt;
      img_size = vecs[i].size;
      bk_load = vecs[i].ld;
      tick();
      chk1($sformatf("vec%0d_ena", i), ena, vecs[i].exp_ena);
      chk1($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk1($sformatf("vec%0d_rd", i), sd_rd, vecs[i].exp_rd);
    end
    img_mounted = 1'b0; img_size = 32'd0; download = 1'b0; bk_load = 1'b0;
    tick();
    check_counts("noimg", 0, 0, 0);

    // Full load from slot 2 with complete sectors.
    for (int k = 0; k < 64; k++) strobes[k] = 512;
    snap();
    start(1'b1, 1'b0, 2'd2);
    serve(1'b1, 2'd2, 3, 64, -1);
    check_counts("load", 64, 0, 1);
    chk1("load_err", err, 1'b0);
    chk1("load_loading", loading, 1'b1);

    // Save to slot 1: byte counts are irrelevant for saves.
    for (int k = 0; k < 64; k++) strobes[k] = int'($urandom_range(0, 8));
    snap();
    start(1'b0, 1'b1, 2'd1);
    serve(1'b0, 2'd1, 2, 64, -1);
    check_counts("save", 0, 64, 1);
    chk1("save_err", err, 1'b0);
    chk1("save_loading", loading, 1'b0);

    // Short sector 5 on a load.
    for (int k = 0; k < 64; k++) strobes[k] = (k < 5) ? 512 : ((k == 5) ? 500 : 0);
    snap();
    start(1'b1, 1'b0, 2'd0);
    serve(1'b1, 2'd0, 1, 64, -1);
    check_counts("short", 64, 0, 1);
    chk1("short_err", err, 1'b1);

    // 1536 bytes must not look like 512 after counter overflow.
    for (int k = 0; k < 64; k++) strobes[k] = (k == 0) ? 1536 : 0;
    snap();
    start(1'b1, 1'b0, 2'd3);
    serve(1'b1, 2'd3, 0, 64, -1);
    check_counts("sat", 64, 0, 1);

    // Both edges together: load wins; a save pulse mid-run is dropped.
    for (int k = 0; k < 64; k++) strobes[k] = int'($urandom_range(0, 3));
    snap();
    start(1'b1, 1'b1, 2'd3);
    serve(1'b1, 2'd3, 1, 64, 20);
    repeat (4) tick();
    check_counts("simul", 64, 0, 1);
    chk1("simul_loading", loading, 1'b1);
    chk1("simul_idle", busy, 1'b0);

    for (int r = 0; r < 3; r++) begin
      dir = 1'($urandom);
      s = 2'($urandom);
      dly = int'($urandom_range(0, 4));
      for (int k = 0; k < 64; k++)
        strobes[k] = ($urandom_range(0, 31) == 0) ? 512 : int'($urandom_range(0, 12));
      snap();
      start(dir, !dir, s);
      serve(dir, s, dly, 64, -1);
      check_counts($sformatf("rand%0d", r), dir ? 64 : 0, dir ? 0 : 64, 1);
    end

    // Abort by download during sector 10 of a save.
    for (int k = 0; k < 64; k++) strobes[k] = 0;
    snap();
    start(1'b0, 1'b1, 2'd1);
    serve(1'b0, 2'd1, 2, 10, -1);
    chk32("abort_lba", sd_lba, 32'd74);
    sd_ack = 1'b1;
    tick();
    tick();
    chk1("abort_req_drop", sd_wr, 1'b0);
    chk1("abort_err_pre", err, 1'b0);
    download = 1'b1;
    tick();
    chk1("abort_err", err, 1'b1);
    chk1("abort_ena", ena, 1'b0);
    chk1("abort_busy", busy, 1'b1);
    chk1("abort_wr", sd_wr, 1'b0);
    repeat (3) tick();
    chk1("drain_hold", busy, 1'b1);
    sd_ack = 1'b0;
    tick();
    chk1("drain_hold2", busy, 1'b1);
    tick();
    chk1("drain_release", busy, 1'b0);
    repeat (3) tick();
    check_counts("abort", 0, 11, 0);
    download = 1'b0;
    tick();
    download = 1'b1;
    tick();
    img_mounted = 1'b1; img_size = 32'd32768;
    tick();
    img_mounted = 1'b0; download = 1'b0;
    tick();
    chk1("remount_ena", ena, 1'b1);

    // Asynchronous reset in the middle of a transfer.
    start(1'b1, 1'b0, 2'd2);
    serve(1'b1, 2'd2, 0, 3, -1);
    sd_ack = 1'b1;
    tick();
    tick();
    sd_buff_wr = 1'b1;
    tick();
    tick();
    RESET_n = 1'b0;
    #2;
    chk32("areset_lba", sd_lba, 32'd0);
    chk1("areset_rd", sd_rd, 1'b0);
    chk1("areset_wr", sd_wr, 1'b0);
    chk1("areset_ena", ena, 1'b0);
    chk1("areset_busy", busy, 1'b0);
    chk1("areset_loading", loading, 1'b0);
    chk1("areset_err", err, 1'b0);
    chk1("areset_done", done, 1'b0);
    sd_buff_wr = 1'b0;
    sd_ack = 1'b0;
    tick();
    RESET_n = 1'b1;
    tick();
    bk_load = 1'b1;
    tick();
    chk1("post_reset_rd", sd_rd, 1'b0);
    chk1("post_reset_busy", busy, 1'b0);
    bk_load = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
